// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and types for the 7-segment scan decoder.
//   SEG_HEX_0..SEG_HEX_F : active-high a..g patterns (bit 0 = a, bit 6 = g)
//   SEG_DP_BIT           : position of the decimal point on the segment bus
//   AN_BLANK             : digit-enable value when no digit is lit
//   scan_state_t         : capture FSM states
package disp_pkg;

   localparam logic [6:0] SEG_HEX_0 = 7'h3F;
   localparam logic [6:0] SEG_HEX_1 = 7'h06;
   localparam logic [6:0] SEG_HEX_2 = 7'h5B;
   localparam logic [6:0] SEG_HEX_3 = 7'h4F;
   localparam logic [6:0] SEG_HEX_4 = 7'h66;
   localparam logic [6:0] SEG_HEX_5 = 7'h6D;
   localparam logic [6:0] SEG_HEX_6 = 7'h7D;
   localparam logic [6:0] SEG_HEX_7 = 7'h07;
   localparam logic [6:0] SEG_HEX_8 = 7'h7F;
   localparam logic [6:0] SEG_HEX_9 = 7'h6F;
   localparam logic [6:0] SEG_HEX_A = 7'h77;
   localparam logic [6:0] SEG_HEX_B = 7'h7C;
   localparam logic [6:0] SEG_HEX_C = 7'h39;
   localparam logic [6:0] SEG_HEX_D = 7'h5E;
   localparam logic [6:0] SEG_HEX_E = 7'h79;
   localparam logic [6:0] SEG_HEX_F = 7'h71;

   localparam int         SEG_DP_BIT = 7;
   localparam logic [3:0] AN_BLANK   = 4'b1111;

   typedef enum logic [1:0] {WAIT, COUNT, HELD} scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 7-segment pattern to hex nibble decoder.
//   i_pat : active-high a..g pattern (bit 0 = a)
//   o_nib : decoded nibble (0 when no match)
//   o_hit : 1 when i_pat is one of the sixteen hex glyphs
module seg7_decode
   import disp_pkg::*;
(
   input  logic [6:0] i_pat,
   output logic [3:0] o_nib,
   output logic       o_hit
);

   always_comb begin
      o_nib = 4'h0;
      o_hit = 1'b1;
      case (i_pat)
         SEG_HEX_0: o_nib = 4'h0;
         SEG_HEX_1: o_nib = 4'h1;
         SEG_HEX_2: o_nib = 4'h2;
         SEG_HEX_3: o_nib = 4'h3;
         SEG_HEX_4: o_nib = 4'h4;
         SEG_HEX_5: o_nib = 4'h5;
         SEG_HEX_6: o_nib = 4'h6;
         SEG_HEX_7: o_nib = 4'h7;
         SEG_HEX_8: o_nib = 4'h8;
         SEG_HEX_9: o_nib = 4'h9;
         SEG_HEX_A: o_nib = 4'hA;
         SEG_HEX_B: o_nib = 4'hB;
         SEG_HEX_C: o_nib = 4'hC;
         SEG_HEX_D: o_nib = 4'hD;
         SEG_HEX_E: o_nib = 4'hE;
         SEG_HEX_F: o_nib = 4'hF;
         default:   o_hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/disp_scan_decoder.sv
// disp_scan_decoder: recovers hex digits and decimal points from a
// multiplexed active-low 7-segment bus and assembles complete frames.
//   clk, rst_n  : clock, synchronous active-low reset
//   an          : active-low digit enables (an[3] -> hexs[15:12])
//   segment     : active-low segments, [6:0] = g..a, [7] = dp
//   hexs/points : last complete frame (points active-high)
//   frame_valid : one-clock pulse when hexs/points update
//   stale       : no frame completed within TIMEOUT_CYC clocks
//   bad_pattern : one-clock pulse on unknown glyph or multi-hot an
//   err_cnt     : saturating bad_pattern count when DISP_SCAN_ERRCNT_EN
//                 is defined, otherwise constant 0
module disp_scan_decoder
   import disp_pkg::*;
#(
   parameter int STABLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 1048576
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  an,
   input  logic [7:0]  segment,
   output logic [15:0] hexs,
   output logic [3:0]  points,
   output logic        frame_valid,
   output logic        stale,
   output logic        bad_pattern,
   output logic [7:0]  err_cnt
);

   localparam int CNT_W = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
   localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYC);
   // Idle bus value; the synchroniser resets to it so a blank bus after
   // reset is not seen as a change.
   localparam logic [11:0] BUS_IDLE = {AN_BLANK, 8'hFF};

   logic [11:0]      r_sync1, r_sync2, r_cmp;
   scan_state_t      r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_seen;
   logic [15:0]      r_sh_hex;
   logic [3:0]       r_sh_dp;
   logic [15:0]      r_hexs;
   logic [3:0]       r_points;
   logic             r_fv, r_bad, r_stale;
   logic [TO_W-1:0]  r_to;

   logic       w_change, w_eval, w_frame, w_one, w_bad, w_hit;
   logic [3:0] w_an, w_anl, w_nib, w_seen_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= BUS_IDLE;
         r_sync2 <= BUS_IDLE;
         r_cmp   <= BUS_IDLE;
      end else begin
         r_sync1 <= {an, segment};
         r_sync2 <= r_sync1;
         r_cmp   <= r_sync2;
      end
   end

   // r_cmp equals r_sync2 whenever w_eval is true, so it is the stable sample.
   assign w_an     = r_cmp[11:8];
   assign w_anl    = ~w_an;
   assign w_change = (r_sync2 != r_cmp);
   assign w_eval   = (r_state == COUNT) && !w_change && (r_cnt == CNT_LAST);
   assign w_frame  = (r_seen == 4'hF);
   // Exactly one digit enable low: non-zero and a power of two.
   assign w_one    = (w_anl != 4'h0) && ((w_anl & (w_anl - 4'd1)) == 4'h0);
   assign w_bad    = (w_an != AN_BLANK) && (!w_one || !w_hit);

   seg7_decode u_dec (
      .i_pat (~r_cmp[6:0]),
      .o_nib (w_nib),
      .o_hit (w_hit)
   );

   always_comb begin
      w_seen_nxt = w_frame ? 4'h0 : r_seen;
      if (w_eval && w_one)
         w_seen_nxt = w_hit ? (w_seen_nxt | w_anl) : (w_seen_nxt & ~w_anl);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= WAIT;
         r_cnt    <= '0;
         r_seen   <= '0;
         r_sh_hex <= '0;
         r_sh_dp  <= '0;
         r_hexs   <= '0;
         r_points <= '0;
         r_fv     <= 1'b0;
         r_bad    <= 1'b0;
      end else begin
         r_fv   <= w_frame;
         r_bad  <= w_eval && w_bad;
         r_seen <= w_seen_nxt;
         if (w_frame) begin
            r_hexs   <= r_sh_hex;
            r_points <= r_sh_dp;
         end
         if (w_eval && w_one && w_hit) begin
            for (int d = 0; d < 4; d++) begin
               if (w_anl[d]) begin
                  r_sh_hex[d*4 +: 4] <= w_nib;
                  r_sh_dp[d]         <= ~r_cmp[SEG_DP_BIT];
               end
            end
         end
         case (r_state)
            WAIT, HELD: begin
               if (w_change) begin
                  r_state <= COUNT;
                  r_cnt   <= '0;
               end
            end
            COUNT: begin
               if (w_change)
                  r_cnt <= '0;
               else if (r_cnt == CNT_LAST)
                  r_state <= HELD;
               else
                  r_cnt <= r_cnt + 1'b1;
            end
            default: r_state <= WAIT;
         endcase
      end
   end

   // Sticky once saturated; only a completed frame (or reset) clears it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_to    <= '0;
         r_stale <= 1'b1;
      end else if (w_frame) begin
         r_to    <= '0;
         r_stale <= 1'b0;
      end else if (r_to != TO_MAX) begin
         r_to <= r_to + 1'b1;
         if (r_to == TO_MAX - 1'b1) r_stale <= 1'b1;
      end
   end

`ifdef DISP_SCAN_ERRCNT_EN
   logic [7:0] r_err;
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_err <= 8'h00;
      else if (r_bad && (r_err != 8'hFF))
         r_err <= r_err + 8'h01;
   end
   assign err_cnt = r_err;
`else
   assign err_cnt = 8'h00;
`endif

   assign hexs        = r_hexs;
   assign points      = r_points;
   assign frame_valid = r_fv;
   assign bad_pattern = r_bad;
   assign stale       = r_stale;

endmodule

// File: tb/tb_disp_scan_decoder.sv
module tb_disp_scan_decoder;

   localparam int STABLE = 16;
   localparam int TMO    = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  an = 4'hF;
   logic [7:0]  segment = 8'hFF;
   logic [15:0] hexs;
   logic [3:0]  points;
   logic        frame_valid, stale, bad_pattern;
   logic [7:0]  err_cnt;

   disp_scan_decoder #(.STABLE_CYC(STABLE), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .an(an), .segment(segment),
      .hexs(hexs), .points(points), .frame_valid(frame_valid),
      .stale(stale), .bad_pattern(bad_pattern), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] hx;
      logic [3:0]  pt;
      logic        st;
   } frame_t;

   logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int checks = 0, errors = 0;

   // reference model: what a viewer would reconstruct from long-enough digits
   logic [3:0]  m_hex [4];
   logic        m_dp  [4];
   logic [3:0]  m_seen;
   logic [11:0] m_bus;
   int          m_run, m_bad = 0, m_err = 0;
   bit          m_done;
   frame_t      exp_q[$], got_q[$];

   // observations
   int   cyc = 0, fv_cyc = -1, st_rise_cyc = -1, got_bad = 0;
   logic prev_stale = 1'b1;

   function automatic logic [3:0] an_of(input int d);
      logic [3:0] one = 4'b0001;
      return ~(one << d);
   endfunction

   function automatic logic [7:0] seg_of(input logic [3:0] nib, input logic dp);
      return {~dp, ~seg_tbl[nib]};
   endfunction

   function automatic bit in_tbl(input logic [6:0] p, output logic [3:0] v);
      v = 4'h0;
      for (int k = 0; k < 16; k++) if (seg_tbl[k] == p) begin v = 4'(k); return 1'b1; end
      return 1'b0;
   endfunction

   function automatic void model_eval(input logic [11:0] b);
      logic [3:0] low = ~b[11:8];
      logic [3:0] v;
      int n = 0, d = 0;
      for (int k = 0; k < 4; k++) if (low[k]) begin n++; d = k; end
      if (n > 1) begin
         m_bad++; m_err++;
      end else if (n == 1) begin
         if (in_tbl(~b[6:0], v)) begin
            m_hex[d] = v; m_dp[d] = ~b[7]; m_seen[d] = 1'b1;
         end else begin
            m_bad++; m_err++; m_seen[d] = 1'b0;
         end
         if (m_seen == 4'hF) begin
            exp_q.push_back('{hx: {m_hex[3], m_hex[2], m_hex[1], m_hex[0]},
                              pt: {m_dp[3], m_dp[2], m_dp[1], m_dp[0]}, st: 1'b0});
            m_seen = 4'h0;
         end
      end
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 4; k++) begin m_hex[k] = 4'h0; m_dp[k] = 1'b0; end
      m_seen = 4'h0; m_bus = 12'hFFF; m_run = 0; m_done = 1'b1; m_err = 0;
   endfunction

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (frame_valid) begin
         got_q.push_back('{hx: hexs, pt: points, st: stale});
         fv_cyc = cyc;
      end
      if (bad_pattern) got_bad++;
      if (stale && !prev_stale) st_rise_cyc = cyc;
      prev_stale = stale;
   endtask

   // Holds the bus for dur clocks; a run of >= 24 clocks is a captured digit,
   // <= 12 clocks is a glitch.
   task automatic show(input logic [3:0] a, input logic [7:0] s, input int dur);
      if ({a, s} == m_bus) m_run += dur;
      else begin m_bus = {a, s}; m_run = dur; m_done = 1'b0; end
      if (!m_done && m_run >= 24) begin model_eval({a, s}); m_done = 1'b1; end
      an = a; segment = s;
      repeat (dur) tick();
   endtask

   task automatic scan_frame(input logic [15:0] hx, input logic [3:0] pt, input int dwell);
      for (int d = 3; d >= 0; d--) show(an_of(d), seg_of(hx[d*4 +: 4], pt[d]), dwell);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0; an = 4'hF; segment = 8'hFF;
      repeat (n) tick();
      rst_n = 1'b1;
      model_reset();
      tick();
   endtask

   task automatic test_reset();
      do_reset(3);
      checks += 6;
      if (hexs !== 16'h0)       begin errors++; $display("FAIL reset_hexs got %h exp 0000", hexs); end
      if (points !== 4'h0)      begin errors++; $display("FAIL reset_points got %h exp 0", points); end
      if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b exp 0", frame_valid); end
      if (bad_pattern !== 1'b0) begin errors++; $display("FAIL reset_bad got %b exp 0", bad_pattern); end
      if (stale !== 1'b1)       begin errors++; $display("FAIL reset_stale got %b exp 1", stale); end
      if (err_cnt !== 8'h00)    begin errors++; $display("FAIL reset_err got %h exp 00", err_cnt); end
   endtask

   task automatic test_clean();
      got_q.delete(); exp_q.delete();
      scan_frame(16'hA5C3, 4'b0100, 64);
      checks += 4;
      if (got_q.size() != 1) begin errors++; $display("FAIL clean_nframes got %0d exp 1", got_q.size()); end
      else begin
         if (got_q[0].hx !== 16'hA5C3) begin errors++; $display("FAIL clean_hexs got %h exp a5c3", got_q[0].hx); end
         if (got_q[0].pt !== 4'b0100)  begin errors++; $display("FAIL clean_points got %b exp 0100", got_q[0].pt); end
         if (got_q[0].st !== 1'b0)     begin errors++; $display("FAIL clean_stale got %b exp 0", got_q[0].st); end
      end
   endtask

   task automatic test_glitch();
      int b0 = got_bad;
      logic [15:0] v = 16'h1234;
      got_q.delete(); exp_q.delete();
      for (int d = 3; d >= 0; d--) begin
         show(an_of(d), seg_of(4'h8, 1'b0), 10);
         show(an_of(d), seg_of(v[d*4 +: 4], 1'b0), 64);
      end
      checks += 3;
      if (got_bad != b0)     begin errors++; $display("FAIL glitch_bad got %0d exp 0", got_bad - b0); end
      if (hexs !== 16'h1234) begin errors++; $display("FAIL glitch_hexs got %h exp 1234", hexs); end
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL glitch_nframes got %0d exp %0d", got_q.size(), exp_q.size()); end
   endtask

   task automatic test_overwrite();
      got_q.delete(); exp_q.delete();
      show(an_of(0), seg_of(4'h7, 1'b0), 64);
      show(an_of(0), seg_of(4'hF, 1'b1), 64);
      show(an_of(3), seg_of(4'h9, 1'b0), 64);
      show(an_of(2), seg_of(4'h6, 1'b0), 64);
      show(an_of(1), seg_of(4'h3, 1'b0), 64);
      checks += 3;
      if (got_q.size() != 1) begin errors++; $display("FAIL ovw_nframes got %0d exp 1", got_q.size()); end
      else if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL ovw_frame got %h exp %h", got_q[0], exp_q[0]); end
      if (hexs !== 16'h963F || points !== 4'b0001) begin errors++; $display("FAIL ovw_hexs got %h/%b exp 963f/0001", hexs, points); end
   endtask

   task automatic test_reset_midframe();
      got_q.delete(); exp_q.delete();
      show(an_of(3), seg_of(4'hB, 1'b0), 64);
      show(an_of(2), seg_of(4'hE, 1'b0), 64);
      do_reset(1);
      show(an_of(1), seg_of(4'hD, 1'b0), 64);
      show(an_of(0), seg_of(4'h2, 1'b0), 64);
      checks += 4;
      if (got_q.size() != 0) begin errors++; $display("FAIL rstmid_nframes got %0d exp 0", got_q.size()); end
      if (hexs !== 16'h0)    begin errors++; $display("FAIL rstmid_hexs got %h exp 0000", hexs); end
      if (points !== 4'h0)   begin errors++; $display("FAIL rstmid_points got %b exp 0000", points); end
      if (stale !== 1'b1)    begin errors++; $display("FAIL rstmid_stale got %b exp 1", stale); end
   endtask

   task automatic test_bad();
      int b0 = got_bad;
      logic [7:0] exp_err;
      got_q.delete(); exp_q.delete();
      show(4'b1110, 8'hFF, 64);
      show(4'b1100, seg_of(4'h3, 1'b0), 64);
`ifdef DISP_SCAN_ERRCNT_EN
      exp_err = 8'd2;
`else
      exp_err = 8'd0;
`endif
      checks += 4;
      if (got_bad - b0 != 2) begin errors++; $display("FAIL bad_pulses got %0d exp 2", got_bad - b0); end
      if (got_bad != m_bad)  begin errors++; $display("FAIL bad_total got %0d exp %0d", got_bad, m_bad); end
      if (got_q.size() != 0) begin errors++; $display("FAIL bad_nframes got %0d exp 0", got_q.size()); end
      if (err_cnt !== exp_err) begin errors++; $display("FAIL bad_errcnt got %0d exp %0d", err_cnt, exp_err); end
   endtask

   task automatic test_timeout();
      got_q.delete(); exp_q.delete();
      st_rise_cyc = -1;
      scan_frame(16'h0F1E, 4'b1001, 64);
      show(4'hF, 8'hFF, 150);
      checks += 3;
      if (got_q.size() != exp_q.size() || got_q.size() == 0) begin
         errors++; $display("FAIL tmo_nframes got %0d exp %0d", got_q.size(), exp_q.size());
      end
      if (st_rise_cyc - fv_cyc != TMO) begin
         errors++; $display("FAIL tmo_rise got %0d clocks exp %0d", st_rise_cyc - fv_cyc, TMO);
      end
      if (stale !== 1'b1) begin errors++; $display("FAIL tmo_stale_hi got %b exp 1", stale); end
      got_q.delete(); exp_q.delete();
      scan_frame(16'h7B8C, 4'b0010, 64);
      checks += 3;
      if (got_q.size() != 1) begin errors++; $display("FAIL tmo_clear_nframes got %0d exp 1", got_q.size()); end
      else if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL tmo_clear_frame got %h exp %h", got_q[0], exp_q[0]); end
      if (stale !== 1'b0) begin errors++; $display("FAIL tmo_clear_stale got %b exp 0", stale); end
   endtask

   task automatic test_random();
      logic [7:0] exp_err;
      got_q.delete(); exp_q.delete();
      for (int i = 0; i < 160; i++) begin
         logic [3:0] a, v;
         logic [6:0] p;
         logic [7:0] s;
         int dur, r;
         do begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
               a = an_of($urandom_range(0, 3));
               s = seg_of(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
               dur = $urandom_range(24, 60);
            end else if (r < 70) begin
               a = 4'hF; s = 8'($urandom_range(0, 255)); dur = $urandom_range(24, 40);
            end else if (r < 78) begin
               do p = 7'($urandom_range(0, 127)); while (in_tbl(p, v));
               a = an_of($urandom_range(0, 3)); s = {1'($urandom_range(0, 1)), ~p};
               dur = $urandom_range(24, 40);
            end else if (r < 85) begin
               do a = 4'($urandom_range(0, 15)); while ($countones(~a) < 2);
               s = 8'($urandom_range(0, 255)); dur = $urandom_range(24, 40);
            end else begin
               a = 4'($urandom_range(0, 15)); s = 8'($urandom_range(0, 255));
               dur = $urandom_range(1, 12);
            end
         end while ({a, s} == m_bus);
         show(a, s, dur);
      end
      show(4'hF, 8'hFF, 30);
`ifdef DISP_SCAN_ERRCNT_EN
      exp_err = (m_err > 255) ? 8'hFF : 8'(m_err);
`else
      exp_err = 8'd0;
`endif
      checks += 3;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_nframes got %0d exp %0d", got_q.size(), exp_q.size()); end
      if (got_bad != m_bad) begin errors++; $display("FAIL rnd_bad got %0d exp %0d", got_bad, m_bad); end
      if (err_cnt !== exp_err) begin errors++; $display("FAIL rnd_errcnt got %0d exp %0d", err_cnt, exp_err); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_frame%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean();
      test_glitch();
      test_overwrite();
      test_reset_midframe();
      test_bad();
      test_timeout();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/disp_scan_decoder.md
# disp_scan_decoder

Recovers the four hex digits and decimal points from a multiplexed, active-low 7-segment display bus (an/segment, as driven by our DispNum scanner). The block filters out scan transitions, decodes each stable segment pattern back to a nibble, and assembles complete frames. It sits on the display bus as a loopback checker or as the capture front-end for another board's display, and feeds frame-level results to downstream logic.

## Interface
- STABLE_CYC, 16: consecutive identical clocks required before a digit is accepted (≥2).
- TIMEOUT_CYC, 1048576: clocks without a completed frame before `stale` asserts.
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- an  in  4  digit enables, active-low; an[3] selects hexs[15:12], an[0] selects hexs[3:0].
- segment  in  8  active-low; [0]=a … [6]=g, [7]=dp.
- hexs  out  16  last complete frame of digits.
- points  out  4  last complete frame of dp bits, active-high, same digit order as `an`.
- frame_valid  out  1  one-clock pulse when hexs/points update.
- stale  out  1  no frame completed within TIMEOUT_CYC.
- bad_pattern  out  1  one-clock pulse on an unrecognised segment pattern or a multi-hot `an`.
- err_cnt  out  8  saturating error count (only with the macro).

## Operation
- **Input stage:** `an` and `segment` pass through a 2-flop synchroniser, then a compare register.
- **Capture FSM**, states WAIT, COUNT, HELD:
  - WAIT to COUNT: any sampled change of {an, segment}.
  - In COUNT, a change restarts the count at 0.
  - At STABLE_CYC identical samples, evaluate once and go to HELD.
  - HELD to COUNT: the next change.
- **Evaluation** (once per stable window):
  - an == 4'b1111 (blank): no action.
  - `an` with more than one bit low: bad_pattern pulse, no write.
  - One-hot-low `an`: decode segment[6:0]. A match writes shadow nibble[d], shadow dp[d] = ~segment[7], and sets seen[d]. No match pulses bad_pattern and sets seen[d] = 0.
- **Decode table** (active-high a..g, inverted on the bus): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. Any other pattern is unrecognised.
- **Same digit captured twice before frame completes:** latest value wins.
- **Frame completion:** when seen == 4'b1111, on the next clock:
  - copy shadows to hexs/points;
  - pulse frame_valid;
  - clear seen;
  - clear the timeout counter.
- **Timeout counter:** increments every clock and saturates at TIMEOUT_CYC. `stale` = (counter == TIMEOUT_CYC).
  - frame_valid clears `stale` in the same cycle.
  - If frame completion and timeout coincide, the frame wins and stale = 0.
- **Reset (rst_n low at any clock edge, including mid-frame or mid-count):**
  - hexs = 0, points = 0, frame_valid = 0, bad_pattern = 0, err_cnt = 0, stale = 1;
  - FSM to WAIT; seen cleared; shadows cleared; counters cleared.

## Timing
- 2-cycle synchroniser latency.
- Evaluation occurs STABLE_CYC clocks after the last input change reaches the compare register.
- frame_valid is registered, 1 clock after the fourth seen bit sets.
- bad_pattern is registered, in the evaluation cycle + 1.
- All outputs are registered; there are no combinational input-to-output paths.
- Digits narrower than STABLE_CYC + 2 clocks are never captured.

## Configuration
- DISP_SCAN_ERRCNT_EN defined:
  - err_cnt increments by 1 on each bad_pattern pulse and saturates at 8'hFF;
  - cleared only by reset.
- DISP_SCAN_ERRCNT_EN undefined:
  - the port remains, tied to 8'h00;
  - no counter logic is present.

## Structure
- **Package disp_pkg:**
  - segment constants SEG_HEX_0..SEG_HEX_F (7-bit, active-high);
  - SEG_DP_BIT = 7;
  - AN_BLANK = 4'b1111;
  - FSM state enum {WAIT, COUNT, HELD}.
- **Sub-module seg7_decode** (combinational): 7-bit pattern in, nibble + hit out. It is shared with future encoders' self-checks.

## Test plan
- **Clean frame:** drive DispNum-style scan for hexs = 16'hA5C3, points = 4'b0100, 64 clks per digit → frame_valid pulse, hexs = 16'hA5C3, points = 4'b0100, stale = 0.
- **Glitch rejection:** insert a 10-clock wrong pattern (8) before each correct digit of 16'h1234, STABLE_CYC = 16 → hexs = 16'h1234, no bad_pattern.
- **Bad input:**
  - segment = 8'hFF with an = 4'b1110 → one bad_pattern pulse, no frame.
  - an = 4'b1100 → one bad_pattern pulse.
  - With DISP_SCAN_ERRCNT_EN, err_cnt = 2.
- **Timeout:** TIMEOUT_CYC = 100, bus held blank → stale rises at clock 100. A subsequent clean frame clears it on its frame_valid cycle.
- **Reset mid-frame:** capture digits 3 and 2, then pulse rst_n low 1 clock, then scan only digits 1 and 0 → no frame_valid; hexs = 0, stale = 1.
- **Overwrite:** digit 0 shown as 7 then F within one frame → frame hexs[3:0] = F.
